// File: rtl/fc_weight_addr_gen.sv
// Address/control sequencer for the FC weight ROM bank: walks a layer fold by fold
// (COLS kernels per fold, KERNEL_SIZE elements each) and emits latency-aligned valid/mask.
module fc_weight_addr_gen #(
    parameter int COLS        = 8,
    parameter int ABS_ADDR_DW = 16,
    parameter int FOLD_GAP    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [15:0]            KERNEL_NUM,
    input  logic [15:0]            KERNEL_SIZE,
    input  logic                   mem_sig,
    input  logic                   ready,
    output logic [15:0]            addr_r,
    output logic [ABS_ADDR_DW-1:0] base_addr,
    output logic [15:0]            rom_select,
    output logic                   data_out_valid,
    output logic                   rd_vld,
    output logic [COLS-1:0]        col_mask,
    output logic                   fold_last,
    output logic                   busy,
    output logic                   done
);
    localparam int GW = (FOLD_GAP > 1) ? $clog2(FOLD_GAP) : 1;
    localparam logic [GW-1:0] GAP_INIT = (FOLD_GAP > 0) ? GW'(FOLD_GAP - 1) : '0;

    typedef enum logic [2:0] {IDLE, WAIT_INIT, STREAM, GAP, FINISH} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            kn_q, kn_d, ks_q, ks_d;
    logic [15:0]            elem_q, elem_d, sel_q, sel_d;
    logic [ABS_ADDR_DW-1:0] base_q, base_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [15:0]            addr_r_q, addr_r_d, rom_select_q, rom_select_d;
    logic [ABS_ADDR_DW-1:0] base_addr_q, base_addr_d;
    logic                   dov_q, dov_d, last_q, last_d;
    logic                   rd_vld_q, rd_vld_d, fold_last_q, fold_last_d;
    logic [COLS-1:0]        col_mask_q, col_mask_d, mask_cur;
    logic                   busy_q, busy_d, done_q, done_d;
    logic                   last_elem, last_fold;

    // Columns past the final kernel of the layer are masked; 17-bit compare avoids wrap.
    for (genvar j = 0; j < COLS; j++) begin : g_mask
        assign mask_cur[j] = ({1'b0, rom_select_q} + 17'(j)) < {1'b0, kn_q};
    end

    assign last_elem = (elem_q == ks_q - 16'd1);
    assign last_fold = ({1'b0, sel_q} + 17'(COLS)) >= {1'b0, kn_q};

    always_comb begin
        state_d      = state_q;
        kn_d         = kn_q;
        ks_d         = ks_q;
        elem_d       = elem_q;
        sel_d        = sel_q;
        base_d       = base_q;
        gap_d        = gap_q;
        addr_r_d     = addr_r_q;
        base_addr_d  = base_addr_q;
        rom_select_d = rom_select_q;
        dov_d        = 1'b0;
        last_d       = 1'b0;
        done_d       = 1'b0;
        rd_vld_d     = dov_q;
        fold_last_d  = dov_q & last_q;
        col_mask_d   = dov_q ? mask_cur : '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    kn_d    = KERNEL_NUM;
                    ks_d    = KERNEL_SIZE;
                    elem_d  = '0;
                    sel_d   = '0;
                    base_d  = '0;
                    state_d = (KERNEL_NUM == 16'd0 || KERNEL_SIZE == 16'd0) ? FINISH : WAIT_INIT;
                end
            end
            WAIT_INIT: begin
                if (mem_sig) state_d = STREAM;
            end
            STREAM: begin
                if (ready) begin
                    dov_d        = 1'b1;
                    addr_r_d     = elem_q;
                    base_addr_d  = base_q;
                    rom_select_d = sel_q;
                    last_d       = last_elem;
                    if (last_elem) begin
                        elem_d = '0;
                        sel_d  = sel_q + 16'(COLS);
                        base_d = base_q + ABS_ADDR_DW'(ks_q);
                        if (last_fold) begin
                            state_d = FINISH;
                        end else if (FOLD_GAP > 0) begin
                            state_d = GAP;
                            gap_d   = GAP_INIT;
                        end
                    end else begin
                        elem_d = elem_q + 16'd1;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) state_d = STREAM;
                else             gap_d   = gap_q - 1'b1;
            end
            FINISH: begin
                // The final rd_vld is produced on this same edge, so done lines up with it.
                done_d       = 1'b1;
                state_d      = IDLE;
                addr_r_d     = '0;
                base_addr_d  = '0;
                rom_select_d = '0;
                elem_d       = '0;
                sel_d        = '0;
                base_d       = '0;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            kn_q         <= '0;
            ks_q         <= '0;
            elem_q       <= '0;
            sel_q        <= '0;
            base_q       <= '0;
            gap_q        <= '0;
            addr_r_q     <= '0;
            base_addr_q  <= '0;
            rom_select_q <= '0;
            dov_q        <= 1'b0;
            last_q       <= 1'b0;
            rd_vld_q     <= 1'b0;
            fold_last_q  <= 1'b0;
            col_mask_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            kn_q         <= kn_d;
            ks_q         <= ks_d;
            elem_q       <= elem_d;
            sel_q        <= sel_d;
            base_q       <= base_d;
            gap_q        <= gap_d;
            addr_r_q     <= addr_r_d;
            base_addr_q  <= base_addr_d;
            rom_select_q <= rom_select_d;
            dov_q        <= dov_d;
            last_q       <= last_d;
            rd_vld_q     <= rd_vld_d;
            fold_last_q  <= fold_last_d;
            col_mask_q   <= col_mask_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign addr_r         = addr_r_q;
    assign base_addr      = base_addr_q;
    assign rom_select     = rom_select_q;
    assign data_out_valid = dov_q;
    assign rd_vld         = rd_vld_q;
    assign col_mask       = col_mask_q;
    assign fold_last      = fold_last_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_fc_weight_addr_gen.sv
// Bench for fc_weight_addr_gen: table-driven layers, directed corner sequences and
// randomized layers checked against an issue-list model built from fold/element loops.
module tb_fc_weight_addr_gen;
    localparam int COLS = 4;
    localparam int GAPC = 2;

    logic        clk = 1'b0;
    logic        rst_n, start, mem_sig, ready;
    logic [15:0] KERNEL_NUM, KERNEL_SIZE;
    logic [15:0] addr_r, base_addr, rom_select;
    logic        data_out_valid, rd_vld, fold_last, busy, done;
    logic [COLS-1:0] col_mask;

    fc_weight_addr_gen #(.COLS(COLS), .ABS_ADDR_DW(16), .FOLD_GAP(GAPC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .KERNEL_NUM(KERNEL_NUM),
        .KERNEL_SIZE(KERNEL_SIZE), .mem_sig(mem_sig), .ready(ready),
        .addr_r(addr_r), .base_addr(base_addr), .rom_select(rom_select),
        .data_out_valid(data_out_valid), .rd_vld(rd_vld), .col_mask(col_mask),
        .fold_last(fold_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] base;
        logic [15:0] sel;
    } iss_t;
    typedef struct packed {
        logic [COLS-1:0] mask;
        logic            last;
    } rd_t;
    typedef struct {
        int kn;
        int ks;
        int n_exp;
        int lat_exp;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    iss_t obs_iss[$], exp_iss[$];
    rd_t  obs_rd[$],  exp_rd[$];
    int   mask_bad, memwait_bad, done_rd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: the layer is just every (fold, element) pair in order.
    task automatic build_model(input int kn, input int ks);
        int folds;
        exp_iss.delete();
        exp_rd.delete();
        folds = (kn == 0 || ks == 0) ? 0 : (kn + COLS - 1) / COLS;
        for (int f = 0; f < folds; f++) begin
            for (int e = 0; e < ks; e++) begin
                iss_t  i;
                rd_t   r;
                i.addr = 16'(e);
                i.base = 16'(f * ks);
                i.sel  = 16'(f * COLS);
                for (int j = 0; j < COLS; j++) r.mask[j] = (f * COLS + j < kn);
                r.last = (e == ks - 1);
                exp_iss.push_back(i);
                exp_rd.push_back(r);
            end
        end
    endtask

    // mode: 0 ready=1, 1 stall 3 cycles after addr0, 2 late mem_sig, 3 restart mid-fold1,
    //       4 random ready, 5 reset mid-fold1
    task automatic run_layer(input int kn, input int ks, input int mode, output int lat);
        bit restarted = 0;
        int stall_left = 3;
        obs_iss.delete();
        obs_rd.delete();
        mask_bad = 0; memwait_bad = 0; done_rd = 0;
        @(negedge clk);
        KERNEL_NUM = 16'(kn); KERNEL_SIZE = 16'(ks);
        start = 1'b1; ready = 1'b1; mem_sig = (mode != 2);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        while (1) begin
            if (data_out_valid) obs_iss.push_back({addr_r, base_addr, rom_select});
            if (rd_vld) obs_rd.push_back({col_mask, fold_last});
            else if (col_mask != '0 || fold_last) mask_bad++;
            if (mode == 2 && lat <= 10 && (!busy || data_out_valid)) memwait_bad++;
            if (done) begin
                done_rd = rd_vld;
                break;
            end
            if (lat >= 600) begin
                chk("timeout", 64'(lat), 64'd0);
                lat = -1;
                return;
            end
            start = 1'b0;
            KERNEL_NUM = 16'($urandom); KERNEL_SIZE = 16'($urandom);
            case (mode)
                1: if (obs_iss.size() == 1 && stall_left > 0) begin
                       ready = 1'b0; stall_left--;
                   end else ready = 1'b1;
                2: mem_sig = (lat >= 10 && lat < 14);
                3: if (obs_iss.size() == 4 && !restarted) begin
                       start = 1'b1; KERNEL_NUM = 16'd2; KERNEL_SIZE = 16'd7; restarted = 1;
                   end
                4: ready = ($urandom_range(0, 3) != 0);
                5: if (obs_iss.size() == 4) begin
                       #1 rst_n = 1'b0;
                       #1 chk("async_rst", {addr_r, base_addr, rom_select, data_out_valid, rd_vld,
                                            col_mask, fold_last, busy, done}, 64'd0);
                       @(negedge clk);
                       chk("rst_hold", {data_out_valid, rd_vld, busy, done}, 64'd0);
                       rst_n = 1'b1;
                       lat = -1;
                       return;
                   end
                default: ready = 1'b1;
            endcase
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_idle", {addr_r, base_addr, rom_select, data_out_valid, rd_vld, col_mask,
                          fold_last, busy, done}, 64'd0);
    endtask

    task automatic check_layer(input string tag, input int kn, input int ks, input int lat,
                               input int lat_exp);
        build_model(kn, ks);
        if (lat_exp >= 0) chk({tag, "_lat"}, 64'(lat), 64'(lat_exp));
        chk({tag, "_n_iss"}, 64'(obs_iss.size()), 64'(exp_iss.size()));
        chk({tag, "_n_rd"}, 64'(obs_rd.size()), 64'(exp_rd.size()));
        for (int i = 0; i < exp_iss.size() && i < obs_iss.size(); i++)
            chk({tag, "_iss"}, 64'(obs_iss[i]), 64'(exp_iss[i]));
        for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
            chk({tag, "_rd"}, 64'(obs_rd[i]), 64'(exp_rd[i]));
        chk({tag, "_mask_idle"}, 64'(mask_bad), 64'd0);
        chk({tag, "_done_rd"}, 64'(done_rd), 64'(exp_iss.size() != 0));
    endtask

    function automatic int lat_formula(input int kn, input int ks);
        int f;
        if (kn == 0 || ks == 0) return 2;
        f = (kn + COLS - 1) / COLS;
        return 3 + f * ks + (f - 1) * GAPC;
    endfunction

    initial begin
        vec_t tbl[7];
        int   lat, kn, ks;
        tbl[0] = '{6, 3, 6, 11};
        tbl[1] = '{8, 1, 2, 7};
        tbl[2] = '{4, 5, 5, 8};
        tbl[3] = '{0, 5, 0, 2};
        tbl[4] = '{5, 0, 0, 2};
        tbl[5] = '{9, 2, 6, 13};
        tbl[6] = '{1, 1, 1, 4};

        rst_n = 1'b0; start = 1'b0; mem_sig = 1'b0; ready = 1'b0;
        KERNEL_NUM = '0; KERNEL_SIZE = '0;
        repeat (3) @(negedge clk);
        chk("reset_addr", {addr_r, base_addr, rom_select}, 64'd0);
        chk("reset_ctl", {data_out_valid, rd_vld, col_mask, fold_last, busy, done}, 64'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_layer(tbl[i].kn, tbl[i].ks, 0, lat);
            check_layer("tbl", tbl[i].kn, tbl[i].ks, lat, tbl[i].lat_exp);
            chk("tbl_count", 64'(obs_iss.size()), 64'(tbl[i].n_exp));
        end

        run_layer(6, 3, 1, lat);
        check_layer("stall", 6, 3, lat, 14);

        run_layer(6, 3, 2, lat);
        check_layer("memlate", 6, 3, lat, 20);
        chk("memwait_busy_novalid", 64'(memwait_bad), 64'd0);

        run_layer(6, 3, 3, lat);
        check_layer("restart", 6, 3, lat, 11);

        run_layer(6, 3, 5, lat);
        run_layer(6, 3, 0, lat);
        check_layer("after_rst", 6, 3, lat, 11);

        for (int n = 0; n < 12; n++) begin
            kn = $urandom_range(0, 13);
            ks = $urandom_range(0, 4);
            run_layer(kn, ks, 0, lat);
            check_layer("rnd", kn, ks, lat, lat_formula(kn, ks));
            kn = $urandom_range(0, 13);
            ks = $urandom_range(0, 4);
            run_layer(kn, ks, 4, lat);
            check_layer("rnd_rdy", kn, ks, lat, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
